// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown expiry alarm.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    ALARM   = 2'd2
  } state_e;

  localparam logic [3:0]  BCD_ZERO    = 4'd0;
  localparam logic [3:0]  LED_SEED    = 4'b0001;
  localparam int unsigned BLINK_CNT_W = 24;

  // Non-BCD digit values simply compare unequal, so they count as nonzero.
  function automatic logic digits_zero(input logic [3:0] m1, input logic [3:0] m0,
                                       input logic [3:0] s1, input logic [3:0] s0);
    return (m1 == BCD_ZERO) && (m0 == BCD_ZERO) && (s1 == BCD_ZERO) && (s0 == BCD_ZERO);
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered single-edge detector; the history flop resets to the input's idle level so
// releasing reset never fabricates an edge.
module edge_pulse #(
  parameter bit   Rise       = 1'b1,
  parameter logic ResetLevel = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    prev_d  = sig_i;
    pulse_d = Rise ? (sig_i & ~prev_q) : (~sig_i & prev_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= ResetLevel;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/timer_expiry_alarm.sv
// Detects countdown expiry at 00:00, stops the counter chain and drives blink/LED/buzzer.
// Define ALARM_AUTO_CLEAR_EN to also clear the alarm after ALARM_SECS seconds.
module timer_expiry_alarm
  import timer_pkg::*;
#(
  parameter int unsigned BLINK_DIV  = 6293750,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       CLK_SEC,
  input  logic [3:0] MIN_1,
  input  logic [3:0] MIN_0,
  input  logic [3:0] SEC_1,
  input  logic [3:0] SEC_0,
  input  logic       ACK_N,
  output logic       STOP_REQ,
  output logic       EXPIRED,
  output logic       DISP_BLANK,
  output logic [3:0] ALARM_LED,
  output logic       BUZZ
);

  localparam logic [BLINK_CNT_W-1:0] BlinkLast = BLINK_CNT_W'(BLINK_DIV - 1);

  state_e                 state_q, state_d;
  logic                   zero_q, zero_d;
  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blank_q, blank_d;
  logic [3:0]             led_q, led_d;
  logic                   sec_p, ack_p, timeout;

  edge_pulse #(.Rise(1'b1), .ResetLevel(1'b0)) u_sec_edge (
    .clk_i  (MCLK),
    .rst_i  (RST),
    .sig_i  (CLK_SEC),
    .pulse_o(sec_p)
  );

  edge_pulse #(.Rise(1'b0), .ResetLevel(1'b1)) u_ack_edge (
    .clk_i  (MCLK),
    .rst_i  (RST),
    .sig_i  (ACK_N),
    .pulse_o(ack_p)
  );

  assign zero_d = digits_zero(MIN_1, MIN_0, SEC_1, SEC_0);

`ifdef ALARM_AUTO_CLEAR_EN
  logic [7:0] sec_cnt_q, sec_cnt_d;

  // Count is held at 0 outside ALARM, so it starts from 0 on every entry.
  always_comb begin
    sec_cnt_d = 8'd0;
    timeout   = 1'b0;
    if (state_q == ALARM) begin
      sec_cnt_d = sec_cnt_q + {7'd0, sec_p};
      timeout   = (sec_cnt_d == 8'(ALARM_SECS));
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) sec_cnt_q <= 8'd0;
    else     sec_cnt_q <= sec_cnt_d;
  end
`else
  logic [7:0] unused_alarm_secs;
  assign unused_alarm_secs = 8'(ALARM_SECS);
  assign timeout           = 1'b0;
`endif

  // Expiry wins over RUN dropping in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (RUN && !zero_q) state_d = RUNNING;
      RUNNING: begin
        if (zero_q)    state_d = ALARM;
        else if (!RUN) state_d = IDLE;
      end
      ALARM:   if (ack_p || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    led_d       = 4'b0000;
    if (state_d == ALARM) begin
      if (state_q != ALARM) begin
        led_d = LED_SEED;
      end else if (blink_cnt_q == BlinkLast) begin
        blank_d = ~blank_q;
        led_d   = {led_q[2:0], led_q[3]};
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blank_d     = blank_q;
        led_d       = led_q;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      zero_q      <= 1'b0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      led_q       <= 4'b0000;
    end else begin
      state_q     <= state_d;
      zero_q      <= zero_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      led_q       <= led_d;
    end
  end

  assign STOP_REQ   = (state_q == ALARM);
  assign EXPIRED    = (state_q == ALARM);
  assign DISP_BLANK = blank_q;
  assign ALARM_LED  = led_q;
  assign BUZZ       = (state_q == ALARM) & ~blank_q;

endmodule

// File: tb/tb_timer_expiry_alarm.sv
// Self-checking bench for timer_expiry_alarm: vector table, corner sequences, random vs model.
module tb_timer_expiry_alarm;

  localparam int unsigned BD   = 4;
  localparam int unsigned SECS = 3;
`ifdef ALARM_AUTO_CLEAR_EN
  localparam bit AutoClear = 1'b1;
`else
  localparam bit AutoClear = 1'b0;
`endif

  logic       MCLK = 1'b0;
  logic       RST, RUN, CLK_SEC, ACK_N;
  logic [3:0] MIN_1, MIN_0, SEC_1, SEC_0;
  logic       STOP_REQ, EXPIRED, DISP_BLANK, BUZZ;
  logic [3:0] ALARM_LED;

  always #5 MCLK = ~MCLK;

  timer_expiry_alarm #(.BLINK_DIV(BD), .ALARM_SECS(SECS)) dut (
    .MCLK      (MCLK),
    .RST       (RST),
    .RUN       (RUN),
    .CLK_SEC   (CLK_SEC),
    .MIN_1     (MIN_1),
    .MIN_0     (MIN_0),
    .SEC_1     (SEC_1),
    .SEC_0     (SEC_0),
    .ACK_N     (ACK_N),
    .STOP_REQ  (STOP_REQ),
    .EXPIRED   (EXPIRED),
    .DISP_BLANK(DISP_BLANK),
    .ALARM_LED (ALARM_LED),
    .BUZZ      (BUZZ)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] outs();
    return {STOP_REQ, EXPIRED, DISP_BLANK, ALARM_LED, BUZZ};
  endfunction

  function automatic logic [7:0] exp_vec(input bit alarm, input bit blank, input logic [3:0] led);
    if (!alarm) return 8'd0;
    return {1'b1, 1'b1, blank, led, ~blank};
  endfunction

  task automatic set_digits(input logic [15:0] d);
    {MIN_1, MIN_0, SEC_1, SEC_0} = d;
  endtask

  // Reference model: mode 0 idle, 1 running, 2 alarm; alarm outputs derived from age.
  int          m_mode;
  int unsigned m_age, m_secs;
  bit          m_zero, m_ack_p, m_sec_p, m_ackn_prev, m_clks_prev;

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_secs = 0;
    m_zero = 0; m_ack_p = 0; m_sec_p = 0;
    m_ackn_prev = 1; m_clks_prev = 0;
  endtask

  task automatic model_step();
    bit timeout;
    timeout = AutoClear && (m_mode == 2) && m_sec_p && (m_secs + 1 >= SECS);
    case (m_mode)
      0: if (RUN && !m_zero) m_mode = 1;
      1: begin
        if (m_zero) begin m_mode = 2; m_age = 0; m_secs = 0; end
        else if (!RUN) m_mode = 0;
      end
      default: begin
        if (m_ack_p || timeout) m_mode = 0;
        else begin m_age++; m_secs += m_sec_p; end
      end
    endcase
    m_zero      = ({MIN_1, MIN_0, SEC_1, SEC_0} == 16'h0000);
    m_ack_p     = m_ackn_prev && !ACK_N;
    m_ackn_prev = ACK_N;
    m_sec_p     = !m_clks_prev && CLK_SEC;
    m_clks_prev = CLK_SEC;
  endtask

  function automatic logic [7:0] model_out();
    int unsigned phase;
    if (m_mode != 2) return 8'd0;
    phase = m_age / BD;
    return exp_vec(1'b1, phase[0], 4'b0001 << (phase % 4));
  endfunction

  task automatic tick();
    @(posedge MCLK);
    if (RST) model_reset();
    else model_step();
    #1;
  endtask

  typedef struct {
    bit          run;
    logic [15:0] dig;
    bit          ack_n;
    bit          alarm;
    bit          blank;
    logic [3:0]  led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit run, input logic [15:0] dig, input bit ack_n,
                              input bit alarm, input bit blank, input logic [3:0] led);
    vec_t v;
    v.run = run; v.dig = dig; v.ack_n = ack_n; v.alarm = alarm; v.blank = blank; v.led = led;
    return v;
  endfunction

  initial begin
    bit exp_alarm;
    // Arm, expire, blink, ack, re-arm, ack-while-running, priority, non-BCD digits.
    vecs.push_back(mk(1, 16'h0002, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0001, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 4'b0001));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0000, 1, 1, 1, 4'b0010));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 4'b0100));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 16'h0000, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0005, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0005, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0005, 0, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0005, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0005, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0009, 0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0009, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0009, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h000A, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h000A, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));
    vecs.push_back(mk(1, 16'h0000, 1, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 4'b0001));
    vecs.push_back(mk(1, 16'h0000, 1, 0, 0, 4'h0));

    RST = 1'b0; RUN = 1'b0; CLK_SEC = 1'b0; ACK_N = 1'b1;
    set_digits(16'h0000);
    model_reset();
    #2 RST = 1'b1;
    #1 check("reset", outs(), 8'd0);
    tick();
    tick();
    RST = 1'b0;

    foreach (vecs[i]) begin
      RUN = vecs[i].run;
      set_digits(vecs[i].dig);
      ACK_N = vecs[i].ack_n;
      tick();
      check($sformatf("vec%0d", i), outs(), exp_vec(vecs[i].alarm, vecs[i].blank, vecs[i].led));
    end

    // Starting at 00:00 never arms.
    RUN = 1'b1;
    set_digits(16'h0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("start_zero", outs(), 8'd0);
    end

    // Alarm hold / auto-clear across CLK_SEC edges.
    set_digits(16'h0002); tick(); tick();
    set_digits(16'h0000); tick(); tick();
    check("arm2", outs(), exp_vec(1'b1, 1'b0, 4'b0001));
    for (int e = 1; e <= 5; e++) begin
      CLK_SEC = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
        tick();
        exp_alarm = !AutoClear || (e < 3) || (e == 3 && ph == 0);
        check($sformatf("sec_edge%0d_ph%0d", e, ph), {6'd0, STOP_REQ, EXPIRED},
              {6'd0, exp_alarm, exp_alarm});
      end
      CLK_SEC = 1'b0;
      tick(); tick();
    end
    ACK_N = 1'b0; tick();
    ACK_N = 1'b1; tick();
    check("ack_exit", outs(), 8'd0);

    // Reset asserted mid-ALARM drops outputs asynchronously, no re-entry after release.
    set_digits(16'h0002); tick(); tick();
    set_digits(16'h0000); tick(); tick();
    check("arm3", {6'd0, STOP_REQ, EXPIRED}, 8'b11);
    for (int i = 0; i < 5; i++) tick();
    #3 RST = 1'b1;
    #1 check("reset_async", outs(), 8'd0);
    set_digits(16'h0003);
    tick(); tick();
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_reset", outs(), 8'd0);
    end

    // Random stimulus against the reference model.
    for (int i = 0; i < 2500; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) RUN = ~RUN;
      case ($urandom_range(0, 3))
        0:       set_digits(16'h0000);
        1:       set_digits(16'($urandom));
        default: set_digits({12'h000, 4'($urandom_range(1, 9))});
      endcase
      ACK_N = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 5) == 0) CLK_SEC = ~CLK_SEC;
      tick();
      check("random", outs(), model_out());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timer_expiry_alarm.md
# timer_expiry_alarm

Downstream consumer of the four BCD countdown digits (MIN_1, MIN_0, SEC_1, SEC_0) on the UP2 timer. It watches the running countdown, detects expiry at 00:00 and requests the counter chain to stop. It then drives the alarm indication: display blink mask, rotating LED pattern and buzzer enable. The alarm is cleared by the debounced button or, optionally, by a timeout.

## Interface
Parameters:
- BLINK_DIV, 6293750, MCLK cycles per blink half-period (2 Hz blink at 25.175 MHz); legal range 2..2^24-1
- ALARM_SECS, 10, alarm duration in seconds when auto-clear is compiled in; legal range 1..255

Ports:
- MCLK  in  1  system clock; single clock domain, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- RUN  in  1  countdown enable level (the ENABLE toggle)
- CLK_SEC  in  1  1 Hz level from clock_sec, MCLK-synchronous; rising edge = one second
- MIN_1, MIN_0, SEC_1, SEC_0  in  4 each  BCD digits from the counters
- ACK_N  in  1  debounced button, 0 while pressed
- STOP_REQ  out  1  1 = gate the counter decrement path
- EXPIRED  out  1  1 while in ALARM
- DISP_BLANK  out  1  1 = blank all four 7-seg digits
- ALARM_LED  out  4  rotating one-hot pattern, 0 outside ALARM
- BUZZ  out  1  buzzer enable

## Operation
- Zero detect: all four digits == 4'd0. The result is registered as zero_q. Non-BCD values (>9) count as nonzero.
- ACK edge: registered falling edge of ACK_N gives a one-cycle ack_p.
- Second edge: registered rising edge of CLK_SEC gives sec_p.
- FSM states: IDLE, RUNNING, ALARM.
  - IDLE→RUNNING: RUN=1 and zero_q=0. Starting at 00:00 never arms.
  - RUNNING→IDLE: RUN=0.
  - RUNNING→ALARM: zero_q=1. This takes priority over RUN=0 in the same cycle.
  - ALARM→IDLE: ack_p=1, or the timeout described under Configuration.
- IDLE and RUNNING outputs: STOP_REQ=0, EXPIRED=0, DISP_BLANK=0, ALARM_LED=0, BUZZ=0.
- ALARM outputs:
  - STOP_REQ=1 and EXPIRED=1.
  - A blink counter counts 0..BLINK_DIV-1. At each wrap, DISP_BLANK toggles and ALARM_LED rotates left (4'b1000→4'b0001).
  - BUZZ = ~DISP_BLANK.
- Leaving ALARM: blink counter, DISP_BLANK and ALARM_LED return to 0 in the same cycle as the transition to IDLE.
- Re-arming after ALARM: RUN still 1 and digits incremented away from 00:00 → back to RUNNING. The FSM passes through IDLE for one cycle.

## Timing
- Reset values: state=IDLE, all outputs 0, all counters and edge registers 0. Edge registers reset to the idle level (ACK_N history=1, CLK_SEC history=0).
- Reset mid-ALARM: outputs drop asynchronously. No spurious ack_p or sec_p is generated on release.
- Expiry latency: digits reach 0000 in cycle N → zero_q=1 in N+1 → state=ALARM and STOP_REQ=1 in N+2. All outputs are registered.
- Entering ALARM loads ALARM_LED=4'b0001, DISP_BLANK=0 and blink counter=0. The first toggle occurs BLINK_DIV cycles after entry.
- ACK latency: ACK_N falls in cycle M → ack_p in M+1 → IDLE with outputs cleared in M+2.
- ack_p in the same cycle as a timeout: single exit to IDLE, no other effect.
- ack_p outside ALARM: ignored.

## Configuration
- ALARM_AUTO_CLEAR_EN defined:
  - An 8-bit seconds counter resets to 0 on ALARM entry and increments on each sec_p while in ALARM.
  - When it reaches ALARM_SECS, the FSM goes ALARM→IDLE on the next cycle.
  - ack_p still clears early.
- Undefined: no seconds counter is synthesized, and ALARM is held until ack_p.

## Structure
- Package timer_pkg:
  - state enum {IDLE, RUNNING, ALARM}
  - BCD_ZERO=4'd0
  - LED_SEED=4'b0001
  - blink counter width constant, 24 bits
- One sub-module, edge_pulse: registered rise/fall detector with async-high reset and a reset-level parameter. It is instantiated twice, for CLK_SEC (rise) and ACK_N (fall).

## Test plan
Bench uses BLINK_DIV=4.
- Reset during ALARM: assert RST → all outputs 0 immediately; release → state IDLE, no alarm re-entry while digits ≠ 0000.
- Arm and expire: digits 00:02, RUN=1, then step digits to 00:00 → STOP_REQ=1 exactly 2 cycles after 0000, ALARM_LED=0001, DISP_BLANK=0.
- Blink: hold in ALARM for 12 cycles → DISP_BLANK toggles at cycles 4, 8, 12; ALARM_LED goes 0010, 0100, 1000; BUZZ = ~DISP_BLANK throughout.
- ACK: pulse ACK_N low in ALARM → all outputs 0 two cycles later. ACK_N low while RUNNING → no effect.
- Start at zero: digits 00:00, RUN=1 → stays IDLE, STOP_REQ=0 indefinitely.
- Auto-clear (ALARM_AUTO_CLEAR_EN defined, ALARM_SECS=3): three CLK_SEC rising edges in ALARM → IDLE one cycle after the third sec_p. Without the macro: still ALARM after 5 edges.
